// File: rtl/core_seq_ctrl_if.sv
// Handshake/instruction bundle between the top-level control and core_seq_ctrl.
interface core_seq_ctrl_if;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        sfu_clr;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  modport master (output start, ofifo_valid,
                  input  inst, sfu_clr, out_valid, out_idx, busy, done);
  modport slave  (input  start, ofifo_valid,
                  output inst, sfu_clr, out_valid, out_idx, busy, done);
endinterface

// File: rtl/core_seq_ctrl.sv
// Sequencer emitting the per-cycle core instruction word for the full conv flow:
// per-kij weight/activation staging, execute, OFIFO->pmem, then 9-psum accumulation per output.
module core_seq_ctrl #(
  parameter int IN_W   = 6,
  parameter int K_W    = 3,
  parameter int COL    = 8,
  parameter int W_BASE = 1024,
  parameter int DRAIN  = 10
) (
  input logic            clk,
  input logic            reset,
  core_seq_ctrl_if.slave bus
);
  localparam int LEN_NIJ  = IN_W*IN_W;
  localparam int LEN_KIJ  = K_W*K_W;
  localparam int O_W      = IN_W-K_W+1;
  localparam int LEN_ONIJ = O_W*O_W;

  localparam logic [6:0] T_COL   = 7'(COL);
  localparam logic [6:0] T_DRAIN = 7'(DRAIN);
  localparam logic [6:0] T_NIJ   = 7'(LEN_NIJ);
  localparam logic [6:0] T_KIJ   = 7'(LEN_KIJ);
  localparam logic [3:0] K_LAST  = 4'(LEN_KIJ-1);
  localparam logic [3:0] KW_LAST = 4'(K_W-1);
  localparam logic [3:0] OW_LAST = 4'(O_W-1);
  localparam logic [3:0] O_LAST  = 4'(LEN_ONIJ-1);

  typedef struct packed {
    logic        acc;
    logic        cen_p;
    logic        wen_p;
    logic [10:0] a_p;
    logic        cen_x;
    logic        wen_x;
    logic [10:0] a_x;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  localparam inst_t INST_RST = '{acc:1'b0, cen_p:1'b1, wen_p:1'b1, a_p:11'd0,
                                 cen_x:1'b1, wen_x:1'b1, a_x:11'd0, ofifo_rd:1'b0,
                                 ififo_wr:1'b0, ififo_rd:1'b0, l0_rd:1'b0, l0_wr:1'b0,
                                 execute:1'b0, load:1'b0};

  typedef enum logic [3:0] {
    IDLE, W_L0, W_LOAD, W_DRAIN, A_L0, EXEC, E_DRAIN, OF_WR, ACC_CLR, ACC_RD, ACC_WAIT
  } state_t;

  state_t     state, state_n;
  logic [6:0] t, t_n;
  logic [3:0] kij, kij_n, ki, ki_n, kj, kj_n, r, r_n, c, c_n, o, o_n;
  logic       pend, pend_n;
  inst_t      inst_q, ni;
  logic       clr_q, clr_n, ov_q, ov_n, done_q, done_n;
  logic [3:0] oidx_q, oidx_n;

  always_comb begin
    state_n = state;
    t_n     = t;
    kij_n   = kij;
    ki_n    = ki;
    kj_n    = kj;
    r_n     = r;
    c_n     = c;
    o_n     = o;
    pend_n  = 1'b0;
    ni      = INST_RST;
    clr_n   = 1'b0;
    ov_n    = 1'b0;
    oidx_n  = oidx_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        state_n = W_L0;
        t_n     = '0;
        kij_n   = '0;
      end
      // xmem read data lands one cycle after CEN, so l0_wr trails each read by one slot
      W_L0: begin
        if (t < T_COL) begin
          ni.cen_x = 1'b0;
          ni.a_x   = 11'(W_BASE + int'(kij)*COL + int'(t));
        end
        ni.l0_wr = (t != 7'd0);
        if (t == T_COL) begin state_n = W_LOAD; t_n = '0; end
        else t_n = t + 7'd1;
      end
      W_LOAD: begin
        ni.l0_rd = 1'b1;
        ni.load  = 1'b1;
        if (t == T_COL - 7'd1) begin state_n = W_DRAIN; t_n = '0; end
        else t_n = t + 7'd1;
      end
      W_DRAIN: begin
        if (t == T_DRAIN - 7'd1) begin state_n = A_L0; t_n = '0; end
        else t_n = t + 7'd1;
      end
      A_L0: begin
        if (t < T_NIJ) begin
          ni.cen_x = 1'b0;
          ni.a_x   = 11'(t);
        end
        ni.l0_wr = (t != 7'd0);
        if (t == T_NIJ) begin state_n = EXEC; t_n = '0; end
        else t_n = t + 7'd1;
      end
      EXEC: begin
        ni.l0_rd   = 1'b1;
        ni.execute = 1'b1;
        if (t == T_NIJ - 7'd1) begin state_n = E_DRAIN; t_n = '0; end
        else t_n = t + 7'd1;
      end
      E_DRAIN: begin
        if (t == T_NIJ - 7'd1) begin state_n = OF_WR; t_n = '0; end
        else t_n = t + 7'd1;
      end
      // t counts OFIFO pops; the write for pop t-1 goes out the cycle after it
      OF_WR: begin
        if (pend) begin
          ni.cen_p = 1'b0;
          ni.wen_p = 1'b0;
          ni.a_p   = 11'(int'(kij)*LEN_NIJ + int'(t) - 1);
        end
        if (t == T_NIJ) begin
          t_n = '0;
          if (kij == K_LAST) begin
            state_n = ACC_CLR;
            kij_n   = '0;
            r_n     = '0;
            c_n     = '0;
            o_n     = '0;
          end else begin
            state_n = W_L0;
            kij_n   = kij + 4'd1;
          end
        end else if (bus.ofifo_valid) begin
          ni.ofifo_rd = 1'b1;
          pend_n      = 1'b1;
          t_n         = t + 7'd1;
        end
      end
      ACC_CLR: begin
        clr_n   = 1'b1;
        state_n = ACC_RD;
        t_n     = '0;
        kij_n   = '0;
        ki_n    = '0;
        kj_n    = '0;
      end
      ACC_RD: begin
        if (t < T_KIJ) begin
          ni.cen_p = 1'b0;
          ni.a_p   = 11'(int'(kij)*LEN_NIJ + (int'(r) + int'(ki))*IN_W + int'(c) + int'(kj));
          kij_n    = kij + 4'd1;
          if (kj == KW_LAST) begin kj_n = '0; ki_n = ki + 4'd1; end
          else kj_n = kj + 4'd1;
        end
        ni.acc = (t != 7'd0);
        if (t == T_KIJ) begin state_n = ACC_WAIT; t_n = '0; end
        else t_n = t + 7'd1;
      end
      // two-cycle SFU latency between the last acc and a valid sfu_out
      ACC_WAIT: begin
        if (t == 7'd1) begin
          ov_n   = 1'b1;
          oidx_n = o;
          t_n    = '0;
          if (o == O_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ACC_CLR;
            o_n     = o + 4'd1;
            if (c == OW_LAST) begin c_n = '0; r_n = r + 4'd1; end
            else c_n = c + 4'd1;
          end
        end else t_n = t + 7'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      t      <= '0;
      kij    <= '0;
      ki     <= '0;
      kj     <= '0;
      r      <= '0;
      c      <= '0;
      o      <= '0;
      pend   <= 1'b0;
      inst_q <= INST_RST;
      clr_q  <= 1'b0;
      ov_q   <= 1'b0;
      oidx_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      t      <= t_n;
      kij    <= kij_n;
      ki     <= ki_n;
      kj     <= kj_n;
      r      <= r_n;
      c      <= c_n;
      o      <= o_n;
      pend   <= pend_n;
      inst_q <= ni;
      clr_q  <= clr_n;
      ov_q   <= ov_n;
      oidx_q <= oidx_n;
      done_q <= done_n;
    end
  end

  assign bus.inst      = inst_q;
  assign bus.sfu_clr   = clr_q;
  assign bus.out_valid = ov_q;
  assign bus.out_idx   = oidx_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: address scoreboards for xmem/pmem traffic and results,
// plus per-cycle checks of the one-cycle lag relations in the instruction stream.
module tb_core_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  core_seq_ctrl_if bus();
  core_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [10:0] exp_xa[$];
  logic [10:0] exp_pw[$];
  logic [10:0] exp_pr[$];
  logic [3:0]  exp_oi[$];
  logic        mon_en = 1'b0;
  int          done_cnt, ov_cnt, clr_cnt;
  logic        p_xr, p_ofrd, p_pr, p_clr, a1, a2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops scoreboards on each DUT transaction and checks cycle-lag relations.
  always @(negedge clk) begin
    logic xr, pw, pr, acc;
    if (reset || !mon_en) begin
      p_xr = 0; p_ofrd = 0; p_pr = 0; p_clr = 0; a1 = 0; a2 = 0;
    end else begin
      xr  = !bus.inst[19];
      pw  = !bus.inst[32] && !bus.inst[31];
      pr  = !bus.inst[32] && bus.inst[31];
      acc = bus.inst[33];
      if (xr) begin
        chk("xmem_we", bus.inst[18], 1'b1);
        chk("xmem_avail", 64'(exp_xa.size() != 0), 1);
        if (exp_xa.size() != 0) chk("xmem_addr", bus.inst[17:7], exp_xa.pop_front());
      end
      if (pw) begin
        chk("pw_avail", 64'(exp_pw.size() != 0), 1);
        if (exp_pw.size() != 0) chk("pmem_wr_addr", bus.inst[30:20], exp_pw.pop_front());
      end
      if (pr) begin
        chk("pr_avail", 64'(exp_pr.size() != 0), 1);
        if (exp_pr.size() != 0) chk("pmem_rd_addr", bus.inst[30:20], exp_pr.pop_front());
        if (!p_pr) chk("clr_before_rd", p_clr, 1'b1);
      end
      if (bus.out_valid) begin
        ov_cnt++;
        chk("oi_avail", 64'(exp_oi.size() != 0), 1);
        if (exp_oi.size() != 0) chk("out_idx", bus.out_idx, exp_oi.pop_front());
      end
      chk("l0_wr_lag", bus.inst[2], p_xr);
      chk("pmem_wr_lag", pw, p_ofrd);
      chk("acc_lag", acc, p_pr);
      chk("out_valid_lat", bus.out_valid, a2 && !a1);
      chk("ififo_idle", bus.inst[5:4], 2'b00);
      if (bus.done) done_cnt++;
      if (bus.sfu_clr) clr_cnt++;
      p_xr = xr; p_ofrd = bus.inst[6]; p_pr = pr; p_clr = bus.sfu_clr;
      a2 = a1; a1 = acc;
    end
  end

  task automatic full_run(input bit extras);
    int n;
    exp_xa.delete(); exp_pw.delete(); exp_pr.delete(); exp_oi.delete();
    for (int k = 0; k < 9; k++) begin
      for (int t = 0; t < 8; t++) exp_xa.push_back(11'(1024 + k*8 + t));
      for (int a = 0; a < 36; a++) exp_xa.push_back(11'(a));
      for (int a = 0; a < 36; a++) exp_pw.push_back(11'(k*36 + a));
    end
    for (int o = 0; o < 16; o++) begin
      for (int ki = 0; ki < 3; ki++)
        for (int kj = 0; kj < 3; kj++)
          exp_pr.push_back(11'((ki*3 + kj)*36 + (o/4 + ki)*6 + (o%4) + kj));
      exp_oi.push_back(4'(o));
    end
    done_cnt = 0; ov_cnt = 0; clr_cnt = 0;
    mon_en = 1'b1;
    bus.ofifo_valid = 1'b1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    if (extras) begin
      n = 0;
      while (!(!bus.inst[32] && !bus.inst[31] && bus.inst[30:20] == 11'd80) && n < 4000) begin
        @(negedge clk); n++;
      end
      chk("reach_kij2_wr", 64'(n < 4000), 1);
      bus.ofifo_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("stall_no_rd", bus.inst[6], 1'b0);
      end
      bus.ofifo_valid = 1'b1;
      @(negedge clk);
      chk("resume_rd", bus.inst[6], 1'b1);
      n = 0;
      while (!(!bus.inst[19] && bus.inst[17:7] == 11'd1056) && n < 4000) begin
        @(negedge clk); n++;
      end
      chk("reach_kij4", 64'(n < 4000), 1);
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk("busy_ignore_start", bus.busy, 1'b1);
    end
    n = 0;
    while (!bus.done && n < 6000) begin @(negedge clk); n++; end
    chk("done_seen", 64'(n < 6000), 1);
    repeat (4) @(negedge clk);
    chk("done_once", 64'(done_cnt), 1);
    chk("out_valid_cnt", 64'(ov_cnt), 16);
    chk("sfu_clr_cnt", 64'(clr_cnt), 16);
    chk("xa_left", 64'(exp_xa.size()), 0);
    chk("pw_left", 64'(exp_pw.size()), 0);
    chk("pr_left", 64'(exp_pr.size()), 0);
    chk("oi_left", 64'(exp_oi.size()), 0);
    chk("idle_busy", bus.busy, 1'b0);
    mon_en = 1'b0;
  endtask

  initial begin
    logic [33:0] rst_inst;
    int n;
    rst_inst = '0;
    rst_inst[32] = 1'b1; rst_inst[31] = 1'b1; rst_inst[19] = 1'b1; rst_inst[18] = 1'b1;
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_inst", bus.inst, rst_inst);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_idx", bus.out_idx, 4'd0);
    chk("rst_clr", bus.sfu_clr, 1'b0);
    // ofifo_valid outside OF_WR and no start: nothing moves
    bus.ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", bus.inst, rst_inst);

    full_run(1'b1);

    // reset in the middle of EXEC
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (!bus.inst[1] && n < 500) begin @(negedge clk); n++; end
    chk("reach_exec", 64'(n < 500), 1);
    repeat (5) @(negedge clk);
    chk("exec_busy", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_inst", bus.inst, rst_inst);
    chk("midrst_busy", bus.busy, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_inst", bus.inst, rst_inst);

    full_run(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
